// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared types and constants for the execute/write-back stage
package exec_pkg;

    localparam int W_DEF      = 8;
    localparam int MUL_CYCLES = W_DEF;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_XOR  = 3'd3,
        OP_SHL  = 3'd4,
        OP_SHR  = 3'd5,
        OP_MUL  = 3'd6,
        OP_PASS = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/exec_iter.sv
// rtl/exec_iter.sv - iteration registers for one-bit-per-cycle shifts and shift-add multiply
module exec_iter
    import exec_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  op_t          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         last,
    output logic [W-1:0] res,
    output logic         cf
);

    localparam int CW = $clog2(W + 1);

    op_t           mode_q;
    logic [W-1:0]  mcand_q;
    logic [W-1:0]  mq_q;
    logic [2*W-1:0] acc_q;
    logic [CW-1:0] cnt_q;

    logic [2*W-1:0] acc_d;
    logic [W:0]     sum_d;
    logic           cy_d;

    // Shifts work in the low half of the accumulator; multiply adds into the
    // high half and shifts the whole product right each step.
    always_comb begin
        acc_d = acc_q;
        sum_d = '0;
        cy_d  = 1'b0;
        case (mode_q)
            OP_SHL: begin
                cy_d  = acc_q[W-1];
                acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], 1'b0};
            end
            OP_SHR: begin
                cy_d  = acc_q[0];
                acc_d = {acc_q[2*W-1:W], 1'b0, acc_q[W-1:1]};
            end
            default: begin
                sum_d = {1'b0, acc_q[2*W-1:W]} + (mq_q[0] ? {1'b0, mcand_q} : '0);
                acc_d = {sum_d, acc_q[W-1:1]};
                cy_d  = |acc_d[2*W-1:W];
            end
        endcase
    end

    assign last = (cnt_q == CW'(1));
    assign res  = acc_d[W-1:0];
    assign cf   = cy_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= OP_ADD;
            mcand_q <= '0;
            mq_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            mode_q  <= op;
            mcand_q <= a;
            mq_q    <= b;
            acc_q   <= (op == OP_MUL) ? '0 : {{W{1'b0}}, a};
            cnt_q   <= (op == OP_MUL) ? CW'(W) : CW'(b[2:0]);
        end else if (step) begin
            acc_q <= acc_d;
            mq_q  <= mq_q >> 1;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - execute/write-back stage driving the register file write port
module exec_unit
    import exec_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  op_t           op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [PW:0]   dst,
    output logic          busy,
    output logic          wr_en,
    output logic [PW:0]   wr_addr,
    output logic [W-1:0]  wr_data,
    output logic          zf,
    output logic          cf
);

    state_t        state_q, state_d;
    logic [PW:0]   dst_q, dst_d;
    logic [PW:0]   wr_addr_q, wr_addr_d;
    logic [W-1:0]  wr_data_q, wr_data_d;
    logic          zf_q, zf_d;
    logic          cf_q, cf_d;

    logic          it_load, it_step, it_last, it_cf;
    logic [W-1:0]  it_res;

    logic [W:0]    sum_w;
    logic [W-1:0]  alu_res;
    logic          alu_cf;
    logic          needs_run;

    exec_iter #(.W(W)) u_iter (
        .clk   (clk),
        .reset (reset),
        .load  (it_load),
        .step  (it_step),
        .op    (op),
        .a     (a),
        .b     (b),
        .last  (it_last),
        .res   (it_res),
        .cf    (it_cf)
    );

    always_comb begin
        sum_w   = '0;
        alu_res = a;
        alu_cf  = 1'b0;
        case (op)
            OP_ADD: begin
                sum_w   = {1'b0, a} + {1'b0, b};
                alu_res = sum_w[W-1:0];
                alu_cf  = sum_w[W];
            end
            OP_SUB: begin
                sum_w   = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                alu_res = sum_w[W-1:0];
                alu_cf  = sum_w[W];
            end
            OP_AND:  alu_res = a & b;
            OP_XOR:  alu_res = a ^ b;
            OP_PASS: alu_res = b;
            default: alu_res = a;
        endcase
    end

    assign needs_run = (op == OP_MUL) ||
                       (((op == OP_SHL) || (op == OP_SHR)) && (b[2:0] != 3'd0));

    always_comb begin
        state_d   = state_q;
        dst_d     = dst_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        zf_d      = zf_q;
        cf_d      = cf_q;
        it_load   = 1'b0;
        it_step   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    it_load = 1'b1;
                    dst_d   = dst;
                    if (needs_run) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d   = ST_DONE;
                        wr_addr_d = dst;
                        wr_data_d = alu_res;
                        zf_d      = (alu_res == '0);
                        cf_d      = alu_cf;
                    end
                end
            end
            ST_RUN: begin
                it_step = 1'b1;
                if (it_last) begin
                    state_d   = ST_DONE;
                    wr_addr_d = dst_q;
                    wr_data_d = it_res;
                    zf_d      = (it_res == '0);
                    cf_d      = it_cf;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dst_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            zf_q      <= 1'b0;
            cf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            dst_q     <= dst_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            zf_q      <= zf_d;
            cf_q      <= cf_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign wr_en   = (state_q == ST_DONE);
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign zf      = zf_q;
    assign cf      = cf_q;

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - scoreboard bench for exec_unit with directed vectors
module tb_exec_unit;
    import exec_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    op_t        op = OP_ADD;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] dst = '0;
    logic       busy, wr_en, zf, cf;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic       zf;
        logic       cf;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exec_unit #(.W(8), .PW(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .dst     (dst),
        .busy    (busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .zf      (zf),
        .cf      (cf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wr_en) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_wr_en", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("wr_addr", int'(wr_addr), int'(e.addr));
                chk("wr_data", int'(wr_data), int'(e.data));
                chk("zf", int'(zf), int'(e.zf));
                chk("cf", int'(cf), int'(e.cf));
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle(input string name, output int bc);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) return;
            bc++;
        end
        chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic issue(input op_t o, input logic [7:0] av, input logic [7:0] bv,
                         input logic [3:0] d, input logic [7:0] ed, input logic ec,
                         input int lat);
        int n, bc;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv; dst = d;
        n = cyc;
        sb_q.push_back('{addr: d, data: ed, zf: (ed == 8'h00), cf: ec, cyc: n + lat});
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("busy_wait", bc);
        chk("busy_cycles", bc, lat);
    endtask

    initial begin
        int n, bc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_flags", int'({zf, cf}), 0);

        issue(OP_ADD,  8'hF0, 8'h20, 4'd5,  8'h10, 1'b1, 1);
        issue(OP_SUB,  8'h05, 8'h05, 4'd1,  8'h00, 1'b1, 1);
        issue(OP_SUB,  8'h03, 8'h04, 4'd2,  8'hFF, 1'b0, 1);
        issue(OP_ADD,  8'hFF, 8'h01, 4'd15, 8'h00, 1'b1, 1);
        issue(OP_AND,  8'hF0, 8'h3C, 4'd3,  8'h30, 1'b0, 1);
        issue(OP_XOR,  8'hAA, 8'hAA, 4'd4,  8'h00, 1'b0, 1);
        issue(OP_PASS, 8'h12, 8'h9C, 4'd6,  8'h9C, 1'b0, 1);
        issue(OP_SHL,  8'h81, 8'h03, 4'd7,  8'h08, 1'b0, 4);
        issue(OP_SHR,  8'h81, 8'h00, 4'd8,  8'h81, 1'b0, 1);
        issue(OP_SHR,  8'h81, 8'h0A, 4'd9,  8'h20, 1'b0, 3);
        issue(OP_SHR,  8'h03, 8'h01, 4'd10, 8'h01, 1'b1, 2);
        issue(OP_SHL,  8'h40, 8'h02, 4'd11, 8'h00, 1'b1, 3);
        issue(OP_SHL,  8'h01, 8'h07, 4'd12, 8'h80, 1'b0, 8);
        issue(OP_MUL,  8'hFF, 8'hFF, 4'd13, 8'h01, 1'b1, 1 + MUL_CYCLES);
        issue(OP_MUL,  8'h10, 8'h11, 4'd14, 8'h10, 1'b1, 1 + MUL_CYCLES);

        // start held high for the whole MUL, then through DONE, with a different op
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 8'h0F; b = 8'h03; dst = 4'd3;
        n = cyc;
        sb_q.push_back('{addr: 4'd3, data: 8'h2D, zf: 1'b0, cf: 1'b0, cyc: n + 9});
        @(posedge clk);
        #1 op = OP_ADD; a = 8'h01; b = 8'h01; dst = 4'd4;
        repeat (9) @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("held_start_not_accepted", int'(busy), 0);

        // reset during RUN cycle 4 of a MUL
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 8'h37; b = 8'h5A; dst = 4'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_run_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_wr_en", int'(wr_en), 0);
        chk("abort_wr_addr", int'(wr_addr), 0);
        chk("abort_wr_data", int'(wr_data), 0);
        chk("abort_flags", int'({zf, cf}), 0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_stays_idle", int'(busy), 0);

        issue(OP_ADD, 8'h21, 8'h13, 4'd2, 8'h34, 1'b0, 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
